// File: rtl/cruise_speed_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// cruise_speed_ctrl_pkg
// Shared definitions for the cruise speed controller.
//   state_e             : FSM state encoding, also driven out on the state port
//   DEF_MIN_SPEED       : default lowest engageable/holdable cruise speed
//   DEF_MAX_SPEED       : default highest engageable/holdable cruise speed
//   DEF_STEP_CYCLES     : default throttle pulse period in clocks
// ---------------------------------------------------------------------------
package cruise_speed_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_OFF     = 2'd0,
    ST_IDLE    = 2'd1,
    ST_CRUISE  = 2'd2,
    ST_SUSPEND = 2'd3
  } state_e;

  localparam logic [7:0] DEF_MIN_SPEED   = 8'd45;
  localparam logic [7:0] DEF_MAX_SPEED   = 8'd200;
  localparam int unsigned DEF_STEP_CYCLES = 4;

endpackage

// File: rtl/btn_edge.sv
// ---------------------------------------------------------------------------
// btn_edge
// Registers a raw button level and flags its rising edge.
//   clk    : system clock
//   rst_n  : asynchronous active-low reset (clears the level history)
//   btn_i  : raw button level
//   edge_o : one-cycle pulse when the registered level goes 0 -> 1
// Because the history resets to 0, a button held through reset release
// yields exactly one edge right after the first clock.
// ---------------------------------------------------------------------------
module btn_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_i,
  output logic edge_o
);

  logic level_q;
  logic prev_q;

  // NOTE: sequential state uses non-blocking assignments only, and the
  // asynchronous reset sits in the sensitivity list so it acts without a clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level_q <= 1'b0;
      prev_q  <= 1'b0;
    end else begin
      level_q <= btn_i;
      prev_q  <= level_q;
    end
  end

  assign edge_o = level_q & ~prev_q;

endmodule

// File: rtl/cruise_speed_ctrl.sv
// ---------------------------------------------------------------------------
// cruise_speed_ctrl
// Cruise control FSM: holds a target speed and issues throttle step requests
// from an external magnitude compare of speed vs. cruise_speed.
//   clk, rst_n                    : clock, asynchronous active-low reset
//   sw_on, sw_off                 : power switch levels (sw_off dominates)
//   set/resume/inc/dec_btn        : raw button levels, acted on at rising edge
//   brake                         : brake pedal level
//   speed                         : current vehicle speed
//   gt, eq, lt                    : speed >, =, < cruise_speed (external)
//   cruise_speed                  : held target speed (compare B operand)
//   throttle_up, throttle_down    : registered single-cycle step requests
//   engaged                       : high only in CRUISE
//   state                         : encoded FSM state
// ---------------------------------------------------------------------------
module cruise_speed_ctrl
  import cruise_speed_ctrl_pkg::*;
#(
  parameter logic [7:0]  MIN_SPEED   = DEF_MIN_SPEED,
  parameter logic [7:0]  MAX_SPEED   = DEF_MAX_SPEED,
  parameter int unsigned STEP_CYCLES = DEF_STEP_CYCLES
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sw_on,
  input  logic       sw_off,
  input  logic       set_btn,
  input  logic       resume_btn,
  input  logic       inc_btn,
  input  logic       dec_btn,
  input  logic       brake,
  input  logic [7:0] speed,
  input  logic       gt,
  input  logic       eq,
  input  logic       lt,
  output logic [7:0] cruise_speed,
  output logic       throttle_up,
  output logic       throttle_down,
  output logic       engaged,
  output logic [1:0] state
);

  localparam int CW = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(STEP_CYCLES - 1);

  logic set_e, resume_e, inc_e, dec_e;

  btn_edge u_set    (.clk(clk), .rst_n(rst_n), .btn_i(set_btn),    .edge_o(set_e));
  btn_edge u_resume (.clk(clk), .rst_n(rst_n), .btn_i(resume_btn), .edge_o(resume_e));
  btn_edge u_inc    (.clk(clk), .rst_n(rst_n), .btn_i(inc_btn),    .edge_o(inc_e));
  btn_edge u_dec    (.clk(clk), .rst_n(rst_n), .btn_i(dec_btn),    .edge_o(dec_e));

  state_e        state_q, state_d;
  logic [7:0]    cs_q, cs_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          up_q, up_d, dn_q, dn_d, eng_q, eng_d;
  logic          speed_ok;
  logic          stay_cruise;

  assign speed_ok = (speed >= MIN_SPEED) && (speed <= MAX_SPEED);

  // NOTE: every variable gets a default at the top of the block so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    cs_d    = cs_q;
    // Only the highest-priority event present is considered; a lower one in
    // the same cycle is dropped even if the higher one has no effect here.
    if (sw_off) begin
      state_d = ST_OFF;
      cs_d    = 8'd0;
    end else begin
      unique case (state_q)
        ST_OFF: begin
          if (sw_on) state_d = ST_IDLE;
        end
        ST_IDLE: begin
          if (!brake && set_e && speed_ok) begin
            state_d = ST_CRUISE;
            cs_d    = speed;
          end
        end
        ST_CRUISE: begin
          if (brake) begin
            state_d = ST_SUSPEND;
          end else if (set_e || resume_e) begin
            state_d = ST_CRUISE;
          end else if (inc_e) begin
            cs_d = (cs_q >= MAX_SPEED) ? MAX_SPEED : cs_q + 8'd1;
          end else if (dec_e) begin
            cs_d = (cs_q <= MIN_SPEED) ? MIN_SPEED : cs_q - 8'd1;
          end
        end
        ST_SUSPEND: begin
          if (brake) begin
            state_d = ST_SUSPEND;
          end else if (set_e) begin
            if (speed_ok) begin
              state_d = ST_CRUISE;
              cs_d    = speed;
            end
          end else if (resume_e && (cs_q != 8'd0)) begin
            state_d = ST_CRUISE;
          end
        end
        default: state_d = ST_OFF;
      endcase
    end
  end

  // The step counter only runs while cruise is held across the edge, so it
  // restarts from 0 on entry and pulses cannot leak out of CRUISE.
  assign stay_cruise = (state_q == ST_CRUISE) && (state_d == ST_CRUISE);

  always_comb begin
    cnt_d = '0;
    up_d  = 1'b0;
    dn_d  = 1'b0;
    eng_d = (state_d == ST_CRUISE);
    if (stay_cruise && !eq) begin
      cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + CW'(1);
      up_d  = (cnt_q == CNT_LAST) && lt;
      dn_d  = (cnt_q == CNT_LAST) && gt && !lt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_OFF;
      cs_q    <= 8'd0;
      cnt_q   <= '0;
      up_q    <= 1'b0;
      dn_q    <= 1'b0;
      eng_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cs_q    <= cs_d;
      cnt_q   <= cnt_d;
      up_q    <= up_d;
      dn_q    <= dn_d;
      eng_q   <= eng_d;
    end
  end

  assign cruise_speed  = cs_q;
  assign throttle_up   = up_q;
  assign throttle_down = dn_q;
  assign engaged       = eng_q;
  assign state         = state_q;

endmodule

// File: tb/tb_cruise_speed_ctrl.sv
// ---------------------------------------------------------------------------
// tb_cruise_speed_ctrl
// Self-checking bench for cruise_speed_ctrl: directed scenarios with literal
// expectations, then randomized stimulus compared every cycle against a
// behavioural model of the controller's rules.
// ---------------------------------------------------------------------------
module tb_cruise_speed_ctrl;

  localparam int MIN_S = 45;
  localparam int MAX_S = 200;
  localparam int STEPS = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       sw_on, sw_off, set_btn, resume_btn, inc_btn, dec_btn, brake;
  logic [7:0] speed;
  logic       gt, eq, lt;
  logic [7:0] cruise_speed;
  logic       throttle_up, throttle_down, engaged;
  logic [1:0] state;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  // External magnitude compare, as it would sit in the vehicle system.
  assign gt = speed >  cruise_speed;
  assign eq = speed == cruise_speed;
  assign lt = speed <  cruise_speed;

  cruise_speed_ctrl dut (
    .clk(clk), .rst_n(rst_n), .sw_on(sw_on), .sw_off(sw_off),
    .set_btn(set_btn), .resume_btn(resume_btn), .inc_btn(inc_btn),
    .dec_btn(dec_btn), .brake(brake), .speed(speed),
    .gt(gt), .eq(eq), .lt(lt), .cruise_speed(cruise_speed),
    .throttle_up(throttle_up), .throttle_down(throttle_down),
    .engaged(engaged), .state(state)
  );

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // States: 0 off, 1 idle, 2 cruise, 3 suspend.
  int       m_state, m_cs, m_cnt, nxt, ncs, ev;
  bit       m_up, m_dn, m_eng;
  bit [3:0] h1, h2, edg;   // button samples from one and two clocks ago

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_state = 0; m_cs = 0; m_cnt = 0; m_up = 0; m_dn = 0; m_eng = 0;
      h1 = '0; h2 = '0;
    end else begin
      edg = h1 & ~h2;
      h2  = h1;
      h1  = {dec_btn, inc_btn, resume_btn, set_btn};
      if (sw_off)      ev = 1;
      else if (brake)  ev = 2;
      else if (edg[0]) ev = 3;
      else if (edg[1]) ev = 4;
      else if (edg[2]) ev = 5;
      else if (edg[3]) ev = 6;
      else             ev = 0;
      nxt = m_state;
      ncs = m_cs;
      case (ev)
        1: begin nxt = 0; ncs = 0; end
        2: if (m_state == 2) nxt = 3;
        3: if ((m_state == 1 || m_state == 3) && speed >= MIN_S && speed <= MAX_S) begin
             nxt = 2; ncs = speed;
           end
        4: if (m_state == 3 && m_cs != 0) nxt = 2;
        5: if (m_state == 2) ncs = (m_cs + 1 > MAX_S) ? MAX_S : m_cs + 1;
        6: if (m_state == 2) ncs = (m_cs - 1 < MIN_S) ? MIN_S : m_cs - 1;
        default: ;
      endcase
      if (ev != 1 && m_state == 0 && sw_on) nxt = 1;
      if (m_state == 2 && nxt == 2 && speed != m_cs) begin
        m_up  = (m_cnt == STEPS - 1) && (speed < m_cs);
        m_dn  = (m_cnt == STEPS - 1) && (speed > m_cs);
        m_cnt = (m_cnt + 1) % STEPS;
      end else begin
        m_up = 0; m_dn = 0; m_cnt = 0;
      end
      m_eng   = (nxt == 2);
      m_state = nxt;
      m_cs    = ncs;
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    check("model_state",    int'(state),         m_state);
    check("model_cs",       int'(cruise_speed),  m_cs);
    check("model_up",       int'(throttle_up),   int'(m_up));
    check("model_down",     int'(throttle_down), int'(m_dn));
    check("model_engaged",  int'(engaged),       int'(m_eng));
    check("up_down_excl",   int'(throttle_up & throttle_down), 0);
  end

  // ---------------- stimulus ----------------
  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  // Button pulse: high for one clock, then give the edge time to act.
  task automatic press(input int which);
    case (which)
      0: set_btn = 1'b1;
      1: resume_btn = 1'b1;
      2: inc_btn = 1'b1;
      default: dec_btn = 1'b1;
    endcase
    tick();
    set_btn = 1'b0; resume_btn = 1'b0; inc_btn = 1'b0; dec_btn = 1'b0;
    tick(2);
  endtask

  task automatic engage_at(input int spd);
    brake = 1'b1; tick(2); brake = 1'b0;
    speed = 8'(spd);
    press(0);
  endtask

  int pulses_up, pulses_dn, r;

  initial begin
    rst_n = 1'b0; sw_on = 0; sw_off = 0; set_btn = 0; resume_btn = 0;
    inc_btn = 0; dec_btn = 0; brake = 0; speed = 8'd0;
    tick(3);
    check("rst_state", int'(state), 0);
    check("rst_cs", int'(cruise_speed), 0);
    check("rst_engaged", int'(engaged), 0);
    rst_n = 1'b1;
    tick(2);
    check("off_hold", int'(state), 0);
    sw_on = 1'b1;
    tick(2);
    check("idle", int'(state), 1);

    // Engage at 100, eq held: no throttle activity.
    speed = 8'd100;
    press(0);
    check("set_state", int'(state), 2);
    check("set_cs", int'(cruise_speed), 100);
    check("set_engaged", int'(engaged), 1);
    pulses_up = 0; pulses_dn = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      pulses_up += throttle_up; pulses_dn += throttle_down;
    end
    check("eq_no_pulse", pulses_up + pulses_dn, 0);

    // Below target: one up pulse every STEPS cycles.
    speed = 8'd90;
    pulses_up = 0; pulses_dn = 0;
    for (int i = 0; i < 16; i++) begin
      tick();
      pulses_up += throttle_up; pulses_dn += throttle_down;
    end
    check("lt_up_pulses", pulses_up, 4);
    check("lt_down_pulses", pulses_dn, 0);
    speed = 8'd100;

    // Increment saturation at MAX.
    engage_at(199);
    check("cs_199", int'(cruise_speed), 199);
    press(2); check("inc1", int'(cruise_speed), 200);
    press(2); check("inc2", int'(cruise_speed), 200);
    press(2); check("inc3", int'(cruise_speed), 200);

    // Decrement saturation at MIN.
    engage_at(46);
    press(3); check("dec1", int'(cruise_speed), 45);
    press(3); check("dec2", int'(cruise_speed), 45);
    press(3); check("dec3", int'(cruise_speed), 45);

    // Brake and set edge in the same cycle: brake wins.
    speed = 8'd60;
    set_btn = 1'b1; tick();
    brake = 1'b1; set_btn = 1'b0; tick(2);
    check("brake_set_state", int'(state), 3);
    check("brake_set_cs", int'(cruise_speed), 45);
    brake = 1'b0; tick();
    press(1);
    check("resume_state", int'(state), 2);
    check("resume_cs", int'(cruise_speed), 45);

    // Out-of-range set from IDLE is ignored.
    sw_off = 1'b1; tick();
    check("sw_off_state", int'(state), 0);
    check("sw_off_cs", int'(cruise_speed), 0);
    sw_off = 1'b0; tick(2);
    speed = 8'd30;
    press(0);
    check("low_set_state", int'(state), 1);
    check("low_set_cs", int'(cruise_speed), 0);

    // Asynchronous reset mid throttle period.
    speed = 8'd100; press(0);
    speed = 8'd90; tick(6);
    #2 rst_n = 1'b0;
    #1;
    check("arst_state", int'(state), 0);
    check("arst_cs", int'(cruise_speed), 0);
    check("arst_up", int'(throttle_up), 0);
    check("arst_down", int'(throttle_down), 0);
    check("arst_engaged", int'(engaged), 0);
    sw_on = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(3);
    check("post_rst_off", int'(state), 0);
    sw_on = 1'b1; tick(2);
    check("post_rst_idle", int'(state), 1);

    // Randomized traffic against the model.
    for (int cyc = 0; cyc < 4000; cyc++) begin
      tick();
      sw_off     = ($urandom_range(0, 79) == 0);
      sw_on      = ($urandom_range(0, 7) != 0);
      brake      = ($urandom_range(0, 15) == 0);
      set_btn    = ($urandom_range(0, 2) == 0);
      resume_btn = ($urandom_range(0, 2) == 0);
      inc_btn    = ($urandom_range(0, 2) == 0);
      dec_btn    = ($urandom_range(0, 2) == 0);
      r = int'($urandom_range(0, 3));
      case (r)
        0: speed = 8'(m_cs);
        1: speed = 8'((m_cs + int'($urandom_range(0, 6)) - 3) & 255);
        2: speed = 8'($urandom_range(0, 255));
        default: speed = 8'($urandom_range(40, 205));
      endcase
      if ($urandom_range(0, 399) == 0) begin
        #2 rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
      end
    end

    tick(2);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
